// File: rtl/nibble_tx_if.sv
// Byte-in / nibble-out bus bundle for nibble_tx.
// slave  : the transmitter (accepts bytes, drives the nibble stream)
// master : the environment (supplies bytes, observes the nibble stream)
interface nibble_tx_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [3:0] din;
  logic       valid;
  logic       toggle;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, din, valid, toggle
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, din, valid, toggle
  );
endinterface

// File: rtl/nibble_tx.sv
// nibble_tx: buffers bytes in a small FIFO and sends each one as two
// valid-qualified nibbles, with toggle flipping once per byte.
// Optional feature macro: CKSUM_EN -- after every PKT_LEN data bytes an
// extra byte carrying the XOR of those bytes is sent with normal framing.
//
// state | meaning
// IDLE  | waiting for a byte (FIFO head or pending checksum); one cycle minimum
// NIB0  | first nibble on din, valid=1
// GAP0  | GAP_CYCLES idle cycles after the first nibble
// NIB1  | second nibble on din, valid=1
// GAP1  | GAP_CYCLES idle cycles after the second nibble
module nibble_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int LSN_FIRST  = 0,
  parameter int PKT_LEN    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  nibble_tx_if.slave                    bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam int         LW       = AW + 1;
  localparam bit         FIRST_HI = (LSN_FIRST == 0);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, NIB0, GAP0, NIB1, GAP1} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, empty, push, pop, load, ck_pending;
  logic [7:0]    head, ld_byte;

  state_t        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic [7:0]    cur_q;
  logic [3:0]    din_q, din_d;
  logic          valid_q, valid_d, toggle_q;

  function automatic logic [3:0] nib_sel(input logic [7:0] b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

  assign full           = (count == LW'(FIFO_DEPTH));
  assign empty          = (count == '0);
  assign bus.byte_ready = reset & ~full;
  assign push           = bus.byte_valid & bus.byte_ready;
  assign head           = mem[rd_ptr];
  // A pending checksum byte goes out before any further FIFO byte.
  assign load           = (state_q == IDLE) & (~empty | ck_pending);
  assign pop            = load & ~ck_pending;

`ifdef CKSUM_EN
  localparam int CW = $clog2(PKT_LEN + 1);
  logic [7:0]    acc_q;
  logic [CW-1:0] cnt_q;

  assign ck_pending = (cnt_q == CW'(PKT_LEN));
  assign ld_byte    = ck_pending ? acc_q : head;

  // Running XOR of data bytes; cleared when the checksum byte is taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      if (ck_pending) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_q ^ head;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  // PKT_LEN has no effect without the checksum feature.
  assign ck_pending = 1'b0 && (PKT_LEN > 0);
  assign ld_byte    = head;
`endif

  // Byte FIFO: pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.byte_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next state plus the next registered din/valid, so nibbles leave a flop.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    din_d   = 4'h0;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        state_d = NIB0;
        valid_d = 1'b1;
        din_d   = nib_sel(ld_byte, FIRST_HI);
      end
      NIB0: if (GAP_CYCLES == 0) begin
        state_d = NIB1;
        valid_d = 1'b1;
        din_d   = nib_sel(cur_q, !FIRST_HI);
      end else begin
        state_d = GAP0;
        gap_d   = GAP_LOAD;
      end
      GAP0: if (gap_q == 4'd0) begin
        state_d = NIB1;
        valid_d = 1'b1;
        din_d   = nib_sel(cur_q, !FIRST_HI);
      end else begin
        gap_d = gap_q - 4'd1;
      end
      NIB1: if (GAP_CYCLES == 0) begin
        state_d = IDLE;
      end else begin
        state_d = GAP1;
        gap_d   = GAP_LOAD;
      end
      GAP1: if (gap_q == 4'd0) state_d = IDLE;
            else gap_d = gap_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end

  // State, gap timer, held byte and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      cur_q    <= '0;
      din_q    <= '0;
      valid_q  <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      valid_q <= valid_d;
      if (load) cur_q <= ld_byte;
      if (state_q == NIB1) toggle_q <= ~toggle_q;
    end
  end

  assign bus.din    = din_q;
  assign bus.valid  = valid_q;
  assign bus.toggle = toggle_q;
  assign busy       = ~empty | (state_q != IDLE) | ck_pending;
  assign level      = count;

endmodule

// File: tb/tb_nibble_tx.sv
// Bench for nibble_tx: dut_a (GAP=1, MSN first), dut_b (GAP=0, LSN first).
// Expected nibbles are queued as bytes are accepted and popped by monitors.
module tb_nibble_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic       busy_a, busy_b;
  logic [2:0] level_a, level_b;

  nibble_tx_if bus_a();
  nibble_tx_if bus_b();

  nibble_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(1), .LSN_FIRST(0), .PKT_LEN(16)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a), .busy(busy_a), .level(level_a));

  nibble_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .LSN_FIRST(1), .PKT_LEN(4)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b), .busy(busy_b), .level(level_b));

  typedef struct packed { logic [3:0] din; logic tog; } nib_t;
  nib_t qa[$];
  nib_t qb[$];
  logic tog_a, tog_b;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic exp_byte_a(input logic [7:0] b);
    qa.push_back(nib_t'({b[7:4], tog_a}));
    qa.push_back(nib_t'({b[3:0], tog_a}));
    tog_a = ~tog_a;
  endtask

  task automatic exp_byte_b(input logic [7:0] b);
    qb.push_back(nib_t'({b[3:0], tog_b}));
    qb.push_back(nib_t'({b[7:4], tog_b}));
    tog_b = ~tog_b;
  endtask

  always @(negedge clk) begin : mon_a
    nib_t e;
    n_cmp++;
    if (bus_a.valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL mon_a: unexpected nibble din=%h toggle=%b, none required", bus_a.din, bus_a.toggle);
      end else begin
        e = qa.pop_front();
        if ({bus_a.din, bus_a.toggle} !== e) begin
          n_fail++;
          $display("FAIL mon_a: din/toggle got %h/%b required %h/%b", bus_a.din, bus_a.toggle, e.din, e.tog);
        end
      end
    end else if (bus_a.din !== 4'h0) begin
      n_fail++;
      $display("FAIL mon_a idle din: got %h required 0", bus_a.din);
    end
  end

  always @(negedge clk) begin : mon_b
    nib_t e;
    n_cmp++;
    if (bus_b.valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL mon_b: unexpected nibble din=%h toggle=%b, none required", bus_b.din, bus_b.toggle);
      end else begin
        e = qb.pop_front();
        if ({bus_b.din, bus_b.toggle} !== e) begin
          n_fail++;
          $display("FAIL mon_b: din/toggle got %h/%b required %h/%b", bus_b.din, bus_b.toggle, e.din, e.tog);
        end
      end
    end else if (bus_b.din !== 4'h0) begin
      n_fail++;
      $display("FAIL mon_b idle din: got %h required 0", bus_b.din);
    end
  end

  task automatic test_reset();
    reset_a = 1'b0; reset_b = 1'b0;
    bus_a.byte_valid = 1'b1; bus_a.byte_in = 8'hFF;
    bus_b.byte_valid = 1'b1; bus_b.byte_in = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_a.valid, bus_a.din, bus_a.toggle, bus_a.byte_ready, level_a} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_a: valid,din,toggle,ready,level got %b required all 0",
                 {bus_a.valid, bus_a.din, bus_a.toggle, bus_a.byte_ready, level_a});
      end
      n_cmp++;
      if ({bus_b.valid, bus_b.din, bus_b.toggle, bus_b.byte_ready, level_b} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_b: valid,din,toggle,ready,level got %b required all 0",
                 {bus_b.valid, bus_b.din, bus_b.toggle, bus_b.byte_ready, level_b});
      end
    end
    @(posedge clk); #1;
    bus_a.byte_valid = 1'b0; bus_b.byte_valid = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;
  endtask

  task automatic test_single_byte();
    // {valid, din, toggle, busy} for cycles 1..7 after the push cycle
    logic [6:0] exp_v [7] = '{7'b0_0000_0_1, 7'b1_1010_0_1, 7'b0_0000_0_1,
                              7'b1_0101_0_1, 7'b0_0000_1_1, 7'b0_0000_1_0,
                              7'b0_0000_1_0};
    @(posedge clk); #1;
    bus_a.byte_in = 8'hA5; bus_a.byte_valid = 1'b1;
    exp_byte_a(8'hA5);
    @(negedge clk);
    n_cmp++;
    if (bus_a.byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single ready c0: got %b required 1", bus_a.byte_ready);
    end
    @(posedge clk); #1;
    bus_a.byte_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_a.valid, bus_a.din, bus_a.toggle, busy_a} !== exp_v[c]) begin
        n_fail++;
        $display("FAIL single c%0d valid,din,toggle,busy: got %b required %b", c + 1,
                 {bus_a.valid, bus_a.din, bus_a.toggle, busy_a}, exp_v[c]);
      end
    end
  endtask

  task automatic test_fill();
    int idx = 0;
    int budget = 0;
    int max_lvl = 0;
    @(posedge clk); #1;
    reset_a = 1'b0; qa.delete(); tog_a = 1'b0;
    @(posedge clk); #1;
    reset_a = 1'b1;
    bus_a.byte_in = 8'h01; bus_a.byte_valid = 1'b1;
    while (idx < 6 && budget < 100) begin
      @(negedge clk);
      budget++;
      n_cmp++;
      if (bus_a.byte_ready !== (level_a != 3'd4)) begin
        n_fail++;
        $display("FAIL fill ready: got %b at level %0d required %b", bus_a.byte_ready, level_a, level_a != 3'd4);
      end
      if (int'(level_a) > max_lvl) max_lvl = int'(level_a);
      if (bus_a.byte_ready) begin
        exp_byte_a(8'(idx + 1));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 6) bus_a.byte_in = 8'(idx + 1);
    end
    bus_a.byte_valid = 1'b0;
    n_cmp++;
    if (idx != 6) begin
      n_fail++;
      $display("FAIL fill accepted: got %0d bytes required 6", idx);
    end
    n_cmp++;
    if (max_lvl != 4) begin
      n_fail++;
      $display("FAIL fill max level: got %0d required 4", max_lvl);
    end
    budget = 0;
    while ((qa.size() != 0 || busy_a) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (qa.size() != 0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fill drain: got %0d nibbles outstanding busy=%b required 0/0", qa.size(), busy_a);
    end
    n_cmp++;
    if ({bus_a.toggle, level_a} !== 4'b0) begin
      n_fail++;
      $display("FAIL fill end toggle,level: got %b/%0d required 0/0", bus_a.toggle, level_a);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bit saw = 0;
    @(posedge clk); #1;
    bus_a.byte_in = 8'h3C; bus_a.byte_valid = 1'b1;
    exp_byte_a(8'h3C);
    @(posedge clk); #1;
    bus_a.byte_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.valid === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset first nibble: got none within 10 cycles required one");
    end
    @(posedge clk); #1;
    reset_a = 1'b0; qa.delete(); tog_a = 1'b0;
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus_a.valid, bus_a.din, bus_a.toggle, level_a, busy_a} !== 10'b0) begin
      n_fail++;
      $display("FAIL midreset after: valid,din,toggle,level,busy got %b required all 0",
               {bus_a.valid, bus_a.din, bus_a.toggle, level_a, busy_a});
    end
    repeat (12) begin
      @(negedge clk);
      if (bus_a.valid === 1'b1) saw = 1;
    end
    n_cmp++;
    if (saw) begin
      n_fail++;
      $display("FAIL midreset abandoned: got nibble after reset required none");
    end
  endtask

  task automatic test_back_to_back();
    // {valid, din, toggle} for cycles 2..7
    logic [5:0] exp_v [6] = '{6'b1_1110_0, 6'b1_1001_0, 6'b0_0000_1,
                              6'b1_0111_1, 6'b1_0100_1, 6'b0_0000_0};
    @(posedge clk); #1;
    bus_b.byte_in = 8'h9E; bus_b.byte_valid = 1'b1;
    exp_byte_b(8'h9E);
    @(negedge clk);
    @(posedge clk); #1;
    bus_b.byte_in = 8'h47;
    exp_byte_b(8'h47);
    @(negedge clk);
    n_cmp++;
    if (bus_b.byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b ready c1: got %b required 1", bus_b.byte_ready);
    end
    @(posedge clk); #1;
    bus_b.byte_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_b.valid, bus_b.din, bus_b.toggle} !== exp_v[c]) begin
        n_fail++;
        $display("FAIL b2b c%0d valid,din,toggle: got %b required %b", c + 2,
                 {bus_b.valid, bus_b.din, bus_b.toggle}, exp_v[c]);
      end
    end
  endtask

`ifdef CKSUM_EN
  task automatic test_checksum();
    logic [31:0] pk [2] = '{32'h12345678, 32'hFF0FF001};
    logic [31:0] w;
    logic [7:0]  ck;
    int idx, budget;
    @(posedge clk); #1;
    reset_b = 1'b0; qb.delete(); tog_b = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    for (int p = 0; p < 2; p++) begin
      w = pk[p]; ck = 8'h00; idx = 0; budget = 0;
      bus_b.byte_in = w[31:24]; bus_b.byte_valid = 1'b1;
      while (idx < 4 && budget < 50) begin
        @(negedge clk);
        budget++;
        if (bus_b.byte_ready) begin
          exp_byte_b(bus_b.byte_in);
          ck = ck ^ bus_b.byte_in;
          idx++;
        end
        @(posedge clk); #1;
        if (idx < 4) bus_b.byte_in = w[31 - 8*idx -: 8];
      end
      bus_b.byte_valid = 1'b0;
      exp_byte_b(ck);
      n_cmp++;
      if (idx != 4) begin
        n_fail++;
        $display("FAIL cksum pkt%0d accepted: got %0d required 4", p, idx);
      end
      budget = 0;
      while ((qb.size() != 0 || busy_b) && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      n_cmp++;
      if (qb.size() != 0 || busy_b !== 1'b0) begin
        n_fail++;
        $display("FAIL cksum pkt%0d drain: got %0d nibbles outstanding busy=%b required 0/0", p, qb.size(), busy_b);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tog_a = 1'b0; tog_b = 1'b0;
    bus_a.byte_in = 8'h00; bus_a.byte_valid = 1'b0;
    bus_b.byte_in = 8'h00; bus_b.byte_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_fill();
    test_reset_mid();
    test_back_to_back();
`ifdef CKSUM_EN
    test_checksum();
`endif
    repeat (4) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL end queues: got %0d/%0d nibbles outstanding required 0/0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
